// File: rtl/button_debounce_pulse_pkg.sv
// ============================================================================
// Module : button_debounce_pulse_pkg
// Brief  : Shared FSM state encoding and default debounce depth.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CHECK_HIGH = 2'd1,
        HIGH       = 2'd2,
        CHECK_LOW  = 2'd3
    } db_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 8;
    localparam int DEFAULT_CNT_WIDTH     = 4;

endpackage : button_debounce_pulse_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : 1-bit two-flop synchroniser with synchronous active-high reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/button_debounce_pulse.sv
// ============================================================================
// Module : button_debounce_pulse
// Brief  : Synchronise, debounce and convert a push-button into one enable
//          pulse per accepted press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debounce_pulse
    import button_debounce_pulse_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic enable_pulse,
    output logic button_level,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic                 w_sync;
    db_state_t            state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 enable_pulse_q;
    logic                 button_level_q;
    logic                 busy_q;

    sync_2ff u_sync (
        .clk (clock),
        .rst (reset),
        .d_i (button_in),
        .q_o (w_sync)
    );

    // cnt_q counts consecutive samples agreeing with the candidate level;
    // it is cleared on every exit from a CHECK state so it never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            enable_pulse_q <= 1'b0;
            button_level_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            enable_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_sync) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= c_CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK_HIGH: begin
                    if (!w_sync) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q        <= HIGH;
                        cnt_q          <= '0;
                        busy_q         <= 1'b0;
                        button_level_q <= 1'b1;
                        enable_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!w_sync) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= c_CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK_LOW: begin
                    if (w_sync) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q        <= IDLE;
                        cnt_q          <= '0;
                        busy_q         <= 1'b0;
                        button_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    cnt_q          <= '0;
                    busy_q         <= 1'b0;
                    button_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign enable_pulse = enable_pulse_q;
    assign button_level = button_level_q;
    assign busy         = busy_q;

endmodule : button_debounce_pulse

`default_nettype wire

// File: tb/tb_button_debounce_pulse.sv
// ============================================================================
// Module : tb_button_debounce_pulse
// Brief  : Self-checking bench for button_debounce_pulse with a pulse-time
//          scoreboard and a downstream 4-bit counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_debounce_pulse;

    localparam int c_LAT = 1 + 8;

    logic clock;
    logic reset;
    logic button_in;
    logic enable_pulse;
    logic button_level;
    logic busy;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];
    int   obs_q[$];
    logic [3:0] count_q;

    button_debounce_pulse #(
        .STABLE_CYCLES (8),
        .CNT_WIDTH     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .enable_pulse (enable_pulse),
        .button_level (button_level),
        .busy         (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (reset)             count_q <= 4'd0;
        else if (enable_pulse) count_q <= count_q + 4'd1;
    end

    // Record the edge number after which each pulse is visible.
    always @(negedge clock) begin
        if (enable_pulse) obs_q.push_back(cyc);
    end

    task automatic check_pulses(input string name);
        int e;
        int o;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s pulse_edge: got %0d required %0d", name, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        int k;
        reset     = 1'b1;
        button_in = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks += 3;
            if (enable_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b required 0", enable_pulse); end
            if (button_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b required 0", button_level); end
            if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        end
        reset = 1'b0;
        k = cyc + 1;
        exp_q.push_back(k + c_LAT);
        repeat (20) @(negedge clock);
        checks++;
        if (button_level !== 1'b1) begin errors++; $display("FAIL reset_after_level: got %b required 1", button_level); end
        check_pulses("reset_release");
        button_in = 1'b0;
        repeat (15) @(negedge clock);
        checks++;
        if (button_level !== 1'b0) begin errors++; $display("FAIL reset_idle_level: got %b required 0", button_level); end
    endtask

    task automatic test_clean_press();
        int   k;
        logic eb;
        logic el;
        button_in = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + c_LAT);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            eb = (cyc >= k + 2) && (cyc < k + c_LAT);
            el = (cyc >= k + c_LAT);
            checks += 2;
            if (busy !== eb)         begin errors++; $display("FAIL clean_busy @%0d: got %b required %b", cyc, busy, eb); end
            if (button_level !== el) begin errors++; $display("FAIL clean_level @%0d: got %b required %b", cyc, button_level, el); end
        end
        check_pulses("clean_press");
    endtask

    task automatic test_release();
        int   k;
        logic eb;
        logic el;
        button_in = 1'b0;
        repeat (5) @(negedge clock);
        button_in = 1'b1;
        repeat (10) begin
            @(negedge clock);
            checks++;
            if (button_level !== 1'b1) begin errors++; $display("FAIL release_glitch_level @%0d: got %b required 1", cyc, button_level); end
        end
        button_in = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            eb = (cyc >= k + 2) && (cyc < k + c_LAT);
            el = (cyc < k + c_LAT);
            checks += 2;
            if (busy !== eb)         begin errors++; $display("FAIL release_busy @%0d: got %b required %b", cyc, busy, eb); end
            if (button_level !== el) begin errors++; $display("FAIL release_level @%0d: got %b required %b", cyc, button_level, el); end
        end
        check_pulses("release");
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b10101;
        for (int b = 4; b >= 0; b--) begin
            button_in = pat[b];
            repeat (3) begin
                @(negedge clock);
                checks++;
                if (button_level !== 1'b0) begin errors++; $display("FAIL bounce_level @%0d: got %b required 0", cyc, button_level); end
            end
        end
        button_in = 1'b0;
        repeat (15) @(negedge clock);
        checks++;
        if (button_level !== 1'b0) begin errors++; $display("FAIL bounce_final_level: got %b required 0", button_level); end
        check_pulses("bounce");
    endtask

    task automatic test_bounce_settle();
        int   k;
        logic el;
        button_in = 1'b1;
        repeat (2) @(negedge clock);
        button_in = 1'b0;
        @(negedge clock);
        button_in = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + c_LAT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            el = (cyc >= k + c_LAT);
            checks++;
            if (button_level !== el) begin errors++; $display("FAIL settle_level @%0d: got %b required %b", cyc, button_level, el); end
        end
        check_pulses("bounce_settle");
        button_in = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    task automatic test_reset_mid_press();
        int   k;
        logic el;
        button_in = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + c_LAT);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks += 3;
        if (enable_pulse !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got %b required 0", enable_pulse); end
        if (button_level !== 1'b0) begin errors++; $display("FAIL midrst_level: got %b required 0", button_level); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
        reset = 1'b0;
        k = cyc + 1;
        exp_q.push_back(k + c_LAT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            el = (cyc >= k + c_LAT);
            checks++;
            if (button_level !== el) begin errors++; $display("FAIL midrst_relevel @%0d: got %b required %b", cyc, button_level, el); end
        end
        check_pulses("reset_mid_press");
        button_in = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    task automatic test_back_to_back_counter();
        int         k;
        logic [3:0] ec;
        button_in = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ec = 4'd0;
        for (int p = 0; p < 17; p++) begin
            button_in = 1'b1;
            k = cyc + 1;
            exp_q.push_back(k + c_LAT);
            repeat (12) @(negedge clock);
            ec = ec + 4'd1;
            checks++;
            if (count_q !== ec) begin errors++; $display("FAIL counter_press%0d: got %b required %b", p + 1, count_q, ec); end
            button_in = 1'b0;
            repeat (12) @(negedge clock);
        end
        checks++;
        if (count_q !== 4'b0001) begin errors++; $display("FAIL counter_final: got %b required 0001", count_q); end
        check_pulses("counter");
    endtask

    initial begin
        reset     = 1'b1;
        button_in = 1'b1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_bounce_settle();
        test_reset_mid_press();
        test_back_to_back_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_debounce_pulse

`default_nettype wire
